cpu_ctrl_fsm: RTL and testbench



---
 rtl/cpu_ctrl_fsm_if.sv | 35 +++
 rtl/cpu_ctrl_fsm.sv | 184 ++++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_fsm_if.sv
// rtl/cpu_ctrl_fsm_if.sv - start/wait handshake, instruction input and datapath control bundle
interface cpu_ctrl_fsm_if #(
  parameter int WIDTH = 16
);
  logic             s;
  logic             load;
  logic [WIDTH-1:0] in;
  logic             w;
  logic [2:0]       writenum;
  logic [2:0]       readnum;
  logic             write;
  logic             loada;
  logic             loadb;
  logic             loadc;
  logic             loads;
  logic             asel;
  logic             bsel;
  logic [1:0]       vsel;
  logic [1:0]       shift;
  logic [1:0]       ALUop;
  logic [WIDTH-1:0] sximm8;
  logic [WIDTH-1:0] sximm5;

  modport master (
    output s, load, in,
    input  w, writenum, readnum, write, loada, loadb, loadc, loads,
    input  asel, bsel, vsel, shift, ALUop, sximm8, sximm5
  );

  modport slave (
    input  s, load, in,
    output w, writenum, readnum, write, loada, loadb, loadc, loads,
    output asel, bsel, vsel, shift, ALUop, sximm8, sximm5
  );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multi-cycle MOV/ADD/CMP/AND/MVN controller; CPU_HALT_EN adds a HALT state for opcode 111
module cpu_ctrl_fsm #(
  parameter int WIDTH = 16
) (
  input logic           clk,
  input logic           reset,
  cpu_ctrl_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WR_REG,
`ifdef CPU_HALT_EN
    S_WR_IMM,
    S_HALT
`else
    S_WR_IMM
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ir_q, ir_d;

  logic       w_q, w_d;
  logic [2:0] writenum_q, writenum_d;
  logic [2:0] readnum_q, readnum_d;
  logic       write_q, write_d;
  logic       loada_q, loada_d;
  logic       loadb_q, loadb_d;
  logic       loadc_q, loadc_d;
  logic       loads_q, loads_d;
  logic       asel_q, asel_d;
  logic [1:0] vsel_q, vsel_d;
  logic [1:0] shift_q, shift_d;
  logic [1:0] aluop_q, aluop_d;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic       is_alu_op, is_mov_reg, is_mvn, is_cmp;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  assign is_alu_op  = (opcode == 3'b101);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_mvn     = is_alu_op && (op == 2'b11);
  assign is_cmp     = is_alu_op && (op == 2'b01);

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_WAIT: begin
        if (bus.load) ir_d = bus.in;
        if (bus.s) state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_WAIT;
        if ((opcode == 3'b110) && (op == 2'b10)) state_d = S_WR_IMM;
        else if (is_mov_reg)                      state_d = S_GET_B;
        else if (is_alu_op)                       state_d = is_mvn ? S_GET_B : S_GET_A;
`ifdef CPU_HALT_EN
        else if (opcode == 3'b111)                state_d = S_HALT;
`endif
      end
      S_GET_A:  state_d = S_GET_B;
      S_GET_B:  state_d = S_ALU;
      S_ALU:    state_d = is_cmp ? S_WAIT : S_WR_REG;
      S_WR_REG: state_d = S_WAIT;
      S_WR_IMM: state_d = S_WAIT;
`ifdef CPU_HALT_EN
      S_HALT:   state_d = S_HALT;
`endif
      default:  state_d = S_WAIT;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it (Moore, no extra latency).
  always_comb begin
    w_d        = 1'b0;
    writenum_d = 3'b000;
    readnum_d  = 3'b000;
    write_d    = 1'b0;
    loada_d    = 1'b0;
    loadb_d    = 1'b0;
    loadc_d    = 1'b0;
    loads_d    = 1'b0;
    asel_d     = 1'b0;
    vsel_d     = 2'b00;
    shift_d    = 2'b00;
    aluop_d    = 2'b00;
    case (state_d)
      S_WAIT: w_d = 1'b1;
      S_GET_A: begin
        readnum_d = rn;
        loada_d   = 1'b1;
      end
      S_GET_B: begin
        readnum_d = rm;
        loadb_d   = 1'b1;
      end
      S_ALU: begin
        shift_d = sh;
        if (is_alu_op) aluop_d = op;
        asel_d  = is_mov_reg || is_mvn;
        loadc_d = !is_cmp;
        loads_d = is_cmp;
      end
      S_WR_REG: begin
        writenum_d = rd;
        write_d    = 1'b1;
      end
      S_WR_IMM: begin
        writenum_d = rn;
        vsel_d     = 2'b10;
        write_d    = 1'b1;
      end
`ifdef CPU_HALT_EN
      S_HALT: w_d = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_WAIT;
      ir_q       <= '0;
      w_q        <= 1'b1;
      writenum_q <= 3'b000;
      readnum_q  <= 3'b000;
      write_q    <= 1'b0;
      loada_q    <= 1'b0;
      loadb_q    <= 1'b0;
      loadc_q    <= 1'b0;
      loads_q    <= 1'b0;
      asel_q     <= 1'b0;
      vsel_q     <= 2'b00;
      shift_q    <= 2'b00;
      aluop_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      w_q        <= w_d;
      writenum_q <= writenum_d;
      readnum_q  <= readnum_d;
      write_q    <= write_d;
      loada_q    <= loada_d;
      loadb_q    <= loadb_d;
      loadc_q    <= loadc_d;
      loads_q    <= loads_d;
      asel_q     <= asel_d;
      vsel_q     <= vsel_d;
      shift_q    <= shift_d;
      aluop_q    <= aluop_d;
    end
  end

  // Strobes are masked by reset directly so an abort in a write state never reaches the register file.
  assign bus.write    = write_q & ~reset;
  assign bus.loada    = loada_q & ~reset;
  assign bus.loadb    = loadb_q & ~reset;
  assign bus.loadc    = loadc_q & ~reset;
  assign bus.loads    = loads_q & ~reset;
  assign bus.w        = w_q;
  assign bus.writenum = writenum_q;
  assign bus.readnum  = readnum_q;
  assign bus.asel     = asel_q;
  assign bus.bsel     = 1'b0;
  assign bus.vsel     = vsel_q;
  assign bus.shift    = shift_q;
  assign bus.ALUop    = aluop_q;
  assign bus.sximm8   = {{(WIDTH-8){ir_q[7]}}, ir_q[7:0]};
  assign bus.sximm5   = {{(WIDTH-5){ir_q[4]}}, ir_q[4:0]};

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb/tb_cpu_ctrl_fsm.sv - table-driven scoreboard bench for cpu_ctrl_fsm (honours CPU_HALT_EN)
module tb_cpu_ctrl_fsm;

  typedef struct packed {
    logic        w;
    logic [2:0]  writenum;
    logic [2:0]  readnum;
    logic        write;
    logic [3:0]  lds;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
  } out_t;

  typedef struct {
    logic        rst;
    logic        s;
    logic        load;
    logic [15:0] din;
    logic        w;
    logic [2:0]  wn;
    logic [2:0]  rn;
    logic        wr;
    logic [3:0]  lds;
    logic        asel;
    logic [1:0]  vsel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] ir;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];
  out_t sb[$];

  cpu_ctrl_fsm_if #(.WIDTH(16)) bus ();

  cpu_ctrl_fsm #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic s, input logic load, input logic [15:0] din,
                     input logic w, input logic [2:0] wn, input logic [2:0] rn, input logic wr,
                     input logic [3:0] lds, input logic asel, input logic [1:0] vsel,
                     input logic [1:0] shift, input logic [1:0] aluop, input logic [15:0] ir);
    vec_t v;
    v.rst = rst; v.s = s; v.load = load; v.din = din;
    v.w = w; v.wn = wn; v.rn = rn; v.wr = wr; v.lds = lds; v.asel = asel;
    v.vsel = vsel; v.shift = shift; v.aluop = aluop; v.ir = ir;
    vecs.push_back(v);
  endtask

  function automatic out_t model_out(input logic w, input logic [2:0] wn, input logic [2:0] rn,
                                     input logic wr, input logic [3:0] lds, input logic asel,
                                     input logic [1:0] vsel, input logic [1:0] shift,
                                     input logic [1:0] aluop, input logic [15:0] ir);
    out_t o;
    o.w = w; o.writenum = wn; o.readnum = rn; o.write = wr; o.lds = lds;
    o.asel = asel; o.bsel = 1'b0; o.vsel = vsel; o.shift = shift; o.aluop = aluop;
    o.sximm8 = {{8{ir[7]}}, ir[7:0]};
    o.sximm5 = {{11{ir[4]}}, ir[4:0]};
    return o;
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o.w = bus.w; o.writenum = bus.writenum; o.readnum = bus.readnum; o.write = bus.write;
    o.lds = {bus.loada, bus.loadb, bus.loadc, bus.loads};
    o.asel = bus.asel; o.bsel = bus.bsel; o.vsel = bus.vsel; o.shift = bus.shift;
    o.aluop = bus.ALUop; o.sximm8 = bus.sximm8; o.sximm5 = bus.sximm5;
    return o;
  endfunction

  task automatic check(input string name);
    out_t exp_o;
    out_t act_o;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, no expected value", name);
    end else begin
      exp_o = sb.pop_front();
      act_o = dut_out();
      n_checks++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL %s: got w=%b wn=%h rn=%h wr=%b lds=%b asel=%b bsel=%b vsel=%b sh=%b alu=%b imm8=%h imm5=%h, want w=%b wn=%h rn=%h wr=%b lds=%b asel=%b bsel=%b vsel=%b sh=%b alu=%b imm8=%h imm5=%h",
                 name, act_o.w, act_o.writenum, act_o.readnum, act_o.write, act_o.lds, act_o.asel, act_o.bsel,
                 act_o.vsel, act_o.shift, act_o.aluop, act_o.sximm8, act_o.sximm5,
                 exp_o.w, exp_o.writenum, exp_o.readnum, exp_o.write, exp_o.lds, exp_o.asel, exp_o.bsel,
                 exp_o.vsel, exp_o.shift, exp_o.aluop, exp_o.sximm8, exp_o.sximm5);
      end
    end
  endtask

  task automatic step(input logic rst, input logic s, input logic load, input logic [15:0] din,
                      input out_t exp_o, input string name);
    @(negedge clk);
    reset = rst; bus.s = s; bus.load = load; bus.in = din;
    sb.push_back(exp_o);
    @(posedge clk);
    #1;
    check(name);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.s    = 1'b0;
    bus.load = 1'b0;
    bus.in   = 16'h0000;

    // rst s ld  in      w  wn rn wr lds     asel vsel   shift  aluop  ir
    add(1, 0, 0, 16'h0000, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'h0000);
    add(1, 0, 0, 16'h0000, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'h0000);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'h0000);
    // MOV R1,#7
    add(0, 0, 1, 16'hD107, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hD107);
    add(0, 1, 0, 16'h0000, 0, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hD107);
    add(0, 0, 0, 16'h0000, 0, 1, 0, 1, 4'b0000, 0, 2'b10, 2'b00, 2'b00, 16'hD107);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hD107);
    // MOV R2,#-2 with s and load together
    add(0, 1, 1, 16'hD2FE, 0, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hD2FE);
    add(0, 0, 0, 16'h0000, 0, 2, 0, 1, 4'b0000, 0, 2'b10, 2'b00, 2'b00, 16'hD2FE);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hD2FE);
    // ADD R3,R1,R2,LSL#1 with a load attempt while busy
    add(0, 0, 1, 16'hA16A, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hA16A);
    add(0, 1, 0, 16'h0000, 0, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hA16A);
    add(0, 0, 1, 16'hFFFF, 0, 0, 1, 0, 4'b1000, 0, 2'b00, 2'b00, 2'b00, 16'hA16A);
    add(0, 0, 0, 16'h0000, 0, 0, 2, 0, 4'b0100, 0, 2'b00, 2'b00, 2'b00, 16'hA16A);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 0, 4'b0010, 0, 2'b00, 2'b01, 2'b00, 16'hA16A);
    add(0, 0, 0, 16'h0000, 0, 3, 0, 1, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hA16A);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hA16A);
    // CMP R1,R2 with s held while busy
    add(0, 0, 1, 16'hA902, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hA902);
    add(0, 1, 0, 16'h0000, 0, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hA902);
    add(0, 1, 0, 16'h0000, 0, 0, 1, 0, 4'b1000, 0, 2'b00, 2'b00, 2'b00, 16'hA902);
    add(0, 1, 0, 16'h0000, 0, 0, 2, 0, 4'b0100, 0, 2'b00, 2'b00, 2'b00, 16'hA902);
    add(0, 1, 0, 16'h0000, 0, 0, 0, 0, 4'b0001, 0, 2'b00, 2'b00, 2'b01, 16'hA902);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hA902);
    // MVN R4,R1
    add(0, 0, 1, 16'hB881, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hB881);
    add(0, 1, 0, 16'h0000, 0, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hB881);
    add(0, 0, 0, 16'h0000, 0, 0, 1, 0, 4'b0100, 0, 2'b00, 2'b00, 2'b00, 16'hB881);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 0, 4'b0010, 1, 2'b00, 2'b00, 2'b11, 16'hB881);
    add(0, 0, 0, 16'h0000, 0, 4, 0, 1, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hB881);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hB881);
    // MOV R7,R1,LSL#1
    add(0, 0, 1, 16'hC0E9, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hC0E9);
    add(0, 1, 0, 16'h0000, 0, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hC0E9);
    add(0, 0, 0, 16'h0000, 0, 0, 1, 0, 4'b0100, 0, 2'b00, 2'b00, 2'b00, 16'hC0E9);
    add(0, 0, 0, 16'h0000, 0, 0, 0, 0, 4'b0010, 1, 2'b00, 2'b01, 2'b00, 16'hC0E9);
    add(0, 0, 0, 16'h0000, 0, 7, 0, 1, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hC0E9);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hC0E9);
    // back-to-back MOV R3,#5 with s held high
    add(0, 1, 1, 16'hD305, 0, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hD305);
    add(0, 1, 0, 16'h0000, 0, 3, 0, 1, 4'b0000, 0, 2'b10, 2'b00, 2'b00, 16'hD305);
    add(0, 1, 0, 16'h0000, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hD305);
    add(0, 1, 0, 16'h0000, 0, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hD305);
    add(0, 0, 0, 16'h0000, 0, 3, 0, 1, 4'b0000, 0, 2'b10, 2'b00, 2'b00, 16'hD305);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hD305);
    // illegal encodings 110/01 and 001
    add(0, 0, 1, 16'hC800, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hC800);
    add(0, 1, 0, 16'h0000, 0, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hC800);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hC800);
    add(0, 1, 1, 16'h2000, 0, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'h2000);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'h2000);
    // opcode 111
    add(0, 0, 1, 16'hE000, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hE000);
    add(0, 1, 0, 16'h0000, 0, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hE000);
`ifdef CPU_HALT_EN
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hE000);
    add(0, 1, 1, 16'h1234, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hE000);
    add(0, 1, 1, 16'hD107, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hE000);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hE000);
`else
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hE000);
    add(0, 0, 1, 16'h1234, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'h1234);
    add(0, 1, 0, 16'h0000, 0, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'h1234);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'h1234);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].s, vecs[i].load, vecs[i].din,
           model_out(vecs[i].w, vecs[i].wn, vecs[i].rn, vecs[i].wr, vecs[i].lds, vecs[i].asel,
                     vecs[i].vsel, vecs[i].shift, vecs[i].aluop, vecs[i].ir),
           $sformatf("vec%0d", i));
    end

    // Abort ADD in WR_REG: the write strobe must drop in the same cycle reset rises.
    step(1, 0, 0, 16'h0000, model_out(1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'h0000), "abort_rst");
    step(0, 0, 1, 16'hA16A, model_out(1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hA16A), "abort_load");
    step(0, 1, 0, 16'h0000, model_out(0, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hA16A), "abort_dec");
    step(0, 0, 0, 16'h0000, model_out(0, 0, 1, 0, 4'b1000, 0, 2'b00, 2'b00, 2'b00, 16'hA16A), "abort_geta");
    step(0, 0, 0, 16'h0000, model_out(0, 0, 2, 0, 4'b0100, 0, 2'b00, 2'b00, 2'b00, 16'hA16A), "abort_getb");
    step(0, 0, 0, 16'h0000, model_out(0, 0, 0, 0, 4'b0010, 0, 2'b00, 2'b01, 2'b00, 16'hA16A), "abort_alu");
    step(0, 0, 0, 16'h0000, model_out(0, 3, 0, 1, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hA16A), "abort_wrreg");
    @(negedge clk);
    reset = 1'b1;
    #1;
    sb.push_back(model_out(0, 3, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'hA16A));
    check("abort_write_masked");
    sb.push_back(model_out(1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'h0000));
    @(posedge clk);
    #1;
    check("abort_wait");
    step(0, 0, 0, 16'h0000, model_out(1, 0, 0, 0, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 16'h0000), "abort_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
